// File: rtl/rr_mux8_1.sv
// rr_mux8_1 -- 8:1 round-robin merging multiplexer with a one-deep output register.
//
// Eight valid/ready lanes are merged into one valid/ready stream. Each output
// beat is tagged with its source lane on sel, so a downstream 1:8 demux driven
// by sel can split the stream back into its lanes. Arbitration starts at a
// round-robin pointer that moves to just past the lane last granted, so any
// lane holding in_valid is served within 8 accepted beats.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : [7:0] lane k presents a beat
//   in_data   : [8*DATA_W-1:0] lane k data at [k*DATA_W +: DATA_W]
//   in_ready  : [7:0] one-hot, lane k's beat is accepted this cycle
//   y         : [DATA_W-1:0] merged output data
//   sel       : [2:0] source lane of the beat on y
//   y_valid   : y/sel hold a valid beat
//   y_ready   : downstream accepts the beat on y
module rr_mux8_1 #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_valid,
  input  logic [8*DATA_W-1:0]   in_data,
  output logic [7:0]            in_ready,
  output logic [DATA_W-1:0]     y,
  output logic [2:0]            sel,
  output logic                  y_valid,
  input  logic                  y_ready
);

  logic [2:0]        ptr;
  logic              load_en;
  logic              found;
  logic [2:0]        g;
  logic [2:0]        idx;
  logic [DATA_W-1:0] gdata;

  // The output register may take a new beat when it is empty or being drained.
  assign load_en = !y_valid || y_ready;

  // Grant search visits ptr, ptr+1, ... ptr+7; the 3-bit add wraps modulo 8.
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end

  // Data selection kept off the in_ready path so in_ready never depends on in_data.
  always_comb begin
    gdata = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (3'(i) == g) begin
        gdata = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // No beat is accepted while reset is applied, since reset overrides any transfer.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && found) begin
      in_ready = 8'd1 << g;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y       <= '0;
      sel     <= '0;
      y_valid <= 1'b0;
      ptr     <= '0;
    end else if (load_en) begin
      if (found) begin
        y       <= gdata;
        sel     <= g;
        y_valid <= 1'b1;
        ptr     <= g + 3'd1;
      end else begin
        // Nothing to load: drop valid, keep y/sel as the last beat.
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux8_1.sv
module tb_rr_mux8_1;

  localparam int DW = 8;

  logic              clk;
  logic              rst_n;
  logic [7:0]        in_valid;
  logic [8*DW-1:0]   in_data;
  logic [7:0]        in_ready;
  logic [DW-1:0]     y;
  logic [2:0]        sel;
  logic              y_valid;
  logic              y_ready;

  rr_mux8_1 #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .y        (y),
    .sel      (sel),
    .y_valid  (y_valid),
    .y_ready  (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  // Reference model: output register contents, pointer, and last accepted lanes.
  logic [DW-1:0] m_y;
  int            m_sel;
  bit            m_valid;
  int            m_ptr;
  logic [7:0]    acc_mask;

  initial begin
    m_y = '0; m_sel = 0; m_valid = 0; m_ptr = 0; acc_mask = '0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // The granted lane is the valid lane at the smallest forward distance from ptr.
  function automatic logic [7:0] model_ready();
    int best;
    best = -1;
    if (!rst_n) return 8'h00;
    if (m_valid && !y_ready) return 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (in_valid[k] === 1'b1) begin
        if (best < 0 || ((k - m_ptr + 8) % 8) < ((best - m_ptr + 8) % 8)) best = k;
      end
    end
    if (best < 0) return 8'h00;
    return 8'(1 << best);
  endfunction

  always @(posedge clk) begin
    logic [7:0] r;
    int g;
    r        = model_ready();
    acc_mask = in_valid & r;
    if (!rst_n) begin
      m_y = '0; m_sel = 0; m_valid = 0; m_ptr = 0;
    end else if (!m_valid || y_ready) begin
      if (acc_mask != 8'h00) begin
        g = 0;
        for (int k = 0; k < 8; k++) if (acc_mask[k]) g = k;
        m_y     = in_data[g*DW +: DW];
        m_sel   = g;
        m_valid = 1;
        m_ptr   = (g + 1) % 8;
      end else begin
        m_valid = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("y_valid",  {31'd0, y_valid}, {31'd0, m_valid});
      chk("y",        {24'd0, y},       {24'd0, m_y});
      chk("sel",      {29'd0, sel},     32'(m_sel));
      chk("in_ready", {24'd0, in_ready}, {24'd0, model_ready()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [7:0] base);
    for (int k = 0; k < 8; k++) in_data[k*DW +: DW] = base + 8'(k);
  endtask

  initial begin
    int dens;
    rst_n = 1'b0; in_valid = 8'h00; y_ready = 1'b0; in_data = '0;
    tick(); tick();
    chk_en = 1'b1;
    // Reset state and in_ready blocked during reset
    chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
    chk("rst_y",       {24'd0, y},       32'd0);
    chk("rst_sel",     {29'd0, sel},     32'd0);
    in_valid = 8'hFF; #1;
    chk("rst_in_ready", {24'd0, in_ready}, 32'h00);
    in_valid = 8'h00;
    tick();

    // Single lane 3
    rst_n = 1'b1; y_ready = 1'b1; in_valid = 8'b0000_1000;
    set_lanes(8'h00); in_data[3*DW +: DW] = 8'hA5; #1;
    chk("single_in_ready", {24'd0, in_ready}, 32'h08);
    tick();
    chk("single_y",     {24'd0, y},       32'hA5);
    chk("single_sel",   {29'd0, sel},     32'd3);
    chk("single_valid", {31'd0, y_valid}, 32'd1);
    in_valid = 8'hFF; #1;
    chk("single_ptr4", {24'd0, in_ready}, 32'h10);

    // All lanes from reset, back-to-back
    rst_n = 1'b0; tick();
    rst_n = 1'b1; set_lanes(8'h00); in_valid = 8'hFF; y_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("all_sel",   {29'd0, sel},     32'(c % 8));
      chk("all_y",     {24'd0, y},       32'(c % 8));
      chk("all_valid", {31'd0, y_valid}, 32'd1);
    end

    // Backpressure: held beat is lane 1, ptr now 2
    y_ready = 1'b0; in_valid = 8'b0010_0100; set_lanes(8'hC0);
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      chk("bp_sel",      {29'd0, sel},      32'd1);
      chk("bp_y",        {24'd0, y},        32'd1);
      chk("bp_in_ready", {24'd0, in_ready}, 32'h00);
    end
    y_ready = 1'b1; #1;
    chk("bp_grant2", {24'd0, in_ready}, 32'h04);
    tick();
    chk("bp_sel2", {29'd0, sel}, 32'd2);
    chk("bp_y2",   {24'd0, y},   32'hC2);
    in_valid = 8'b0010_0000; #1;
    chk("bp_grant5", {24'd0, in_ready}, 32'h20);
    tick();
    chk("bp_sel5", {29'd0, sel}, 32'd5);

    // Wrap: lane 6 puts ptr at 7
    in_valid = 8'h40; tick();
    in_valid = 8'h81; #1;
    chk("wrap_grant7", {24'd0, in_ready}, 32'h80);
    tick();
    chk("wrap_sel7", {29'd0, sel}, 32'd7);
    in_valid = 8'h01; #1;
    chk("wrap_grant0", {24'd0, in_ready}, 32'h01);
    tick();
    chk("wrap_sel0", {29'd0, sel}, 32'd0);
    in_valid = 8'h03; #1;
    chk("wrap_ptr1", {24'd0, in_ready}, 32'h02);
    tick();
    chk("wrap_sel1", {29'd0, sel}, 32'd1);

    // Drain
    in_valid = 8'h00; tick();
    chk("drain_valid", {31'd0, y_valid}, 32'd0);
    chk("drain_y",     {24'd0, y},       32'hC1);
    chk("drain_sel",   {29'd0, sel},     32'd1);

    // Reset while holding lane 5
    in_valid = 8'h20; tick();
    y_ready = 1'b0; in_valid = 8'h08; tick();
    chk("mr_sel5", {29'd0, sel}, 32'd5);
    rst_n = 1'b0; tick();
    chk("mr_valid", {31'd0, y_valid}, 32'd0);
    chk("mr_y",     {24'd0, y},       32'd0);
    chk("mr_sel",   {29'd0, sel},     32'd0);
    rst_n = 1'b1; y_ready = 1'b1; in_valid = 8'h28; #1;
    chk("mr_grant3", {24'd0, in_ready}, 32'h08);
    tick();
    chk("mr_sel3", {29'd0, sel}, 32'd3);

    // Randomized traffic with lanes holding until accepted
    in_valid = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      dens = (c / 500) % 3 == 0 ? 90 : ((c / 500) % 3 == 1 ? 30 : 60);
      for (int k = 0; k < 8; k++) begin
        if (!(in_valid[k] && !acc_mask[k])) begin
          in_valid[k] = ($urandom_range(0, 99) < dens);
          in_data[k*DW +: DW] = 8'($urandom);
        end
      end
      y_ready = ($urandom_range(0, 3) != 0);
      rst_n   = ($urandom_range(0, 127) != 0);
      tick();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_mux8_1.md
RR_MUX8_1 -- requirements
Module: rr_mux8_1

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of each lane's data.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 8 bits: bit k means lane k presents a beat.
REQ-005 The block SHALL have port in_data, input, 8*DATA_W bits: lane k data occupies bits [k*DATA_W +: DATA_W].
REQ-006 The block SHALL have port in_ready, output, 8 bits: bit k means lane k's beat is accepted this cycle.
REQ-007 The block SHALL have port y, output, DATA_W bits: the merged output data.
REQ-008 The block SHALL have port sel, output, 3 bits: the source lane index of the beat on y.
REQ-009 The block SHALL have port y_valid, output, 1 bit: y and sel hold a valid beat.
REQ-010 The block SHALL have port y_ready, input, 1 bit: the downstream consumer accepts the beat.

Function
REQ-011 The block SHALL merge 8 lanes into one stream tagged with sel, so that a downstream 1:8 demux driven by sel restores each lane.
REQ-012 The block SHALL hold one output register (y, sel, y_valid) and a 3-bit round-robin pointer ptr.
- load_en = !y_valid || y_ready.
REQ-013 The block SHALL compute the grant g combinationally as the first k with in_valid[k]=1, searching ptr, ptr+1, ... ptr+7 mod 8.
REQ-014 in_ready SHALL be one-hot at bit g when load_en=1 and any in_valid bit is 1; otherwise in_ready SHALL be 8'h00.
REQ-015 A transfer on lane k SHALL occur when in_valid[k] && in_ready[k]. On that clock edge:
- y <= lane k data
- sel <= k
- y_valid <= 1
- ptr <= (k+1) mod 8, wrapping 7 -> 0
REQ-016 If load_en=1 and in_valid=8'h00, y_valid SHALL go to 0 on the next edge. y and sel SHALL hold their last values.
REQ-017 While y_valid=1 and y_ready=0, y, sel, y_valid and ptr SHALL remain stable, and in_ready SHALL be 8'h00.
REQ-018 Simultaneous output consume and input accept (y_valid=1, y_ready=1, a request present) SHALL load the new beat with no bubble, sustaining 1 beat/cycle.
REQ-019 Latency SHALL be 1 cycle: a beat accepted at edge N appears on y/sel with y_valid=1 after edge N.
REQ-020 in_ready SHALL depend on in_valid, ptr, y_valid and y_ready only, never on in_data.
REQ-021 A lane that keeps in_valid=1 SHALL be granted within 8 accepted beats (no starvation).
REQ-022 Lanes are required to hold in_valid and data until accepted; the block SHALL NOT buffer unaccepted beats.

Reset
REQ-023 When rst_n=0 at a rising edge, the block SHALL set y=0, sel=3'b000, y_valid=0 and ptr=0, overriding any transfer in that cycle.
REQ-024 During reset, in_ready SHALL be 8'h00.
REQ-025 A reset asserted while y_valid=1 SHALL discard the held beat, with no output for it after reset.

Verification
REQ-026 Single lane: y_ready=1, in_valid=8'b0000_1000, lane3 data=8'hA5.
- Expected: in_ready=8'b0000_1000.
- Next cycle: y=A5, sel=3, y_valid=1, ptr=4.
REQ-027 All lanes valid, lane k data=k, y_ready=1, 10 cycles from reset.
- Expected: sel sequence 0,1,...,7,0,1, back-to-back with no bubble.
REQ-028 Backpressure: a beat is held with y_ready=0 for 3 cycles while lanes 2 and 5 are valid.
- Expected: y/sel stable and in_ready=0 throughout.
- On y_ready=1: lane grants follow the ptr order.
REQ-029 Wrap: ptr=7, in_valid=8'b1000_0001.
- Expected: lane 7 is granted first, then lane 0, and ptr becomes 1.
REQ-030 Reset mid-operation: rst_n=0 for 1 cycle while y_valid=1 and sel=5.
- Expected: y_valid=0, y=0, sel=0 next cycle, and the first grant afterwards starts searching from lane 0.
REQ-031 Drain: in_valid drops to 0 with y_ready=1.
- Expected: y_valid=0 one cycle after the last beat is consumed.
- Expected: y and sel retain the last values.
